// File: rtl/gfx_pkg.sv
// Shared graphics definitions for the point-to-framebuffer path.
// Holds the default screen geometry, framebuffer widths and the packed pixel
// entry layout {addr, color} used by the pixel writer and its FIFO.
package gfx_pkg;

   localparam int unsigned H_RES_DEF   = 160;
   localparam int unsigned V_RES_DEF   = 120;
   localparam int unsigned FB_ADDR_W   = 15;
   localparam int unsigned COLOR_W_DEF = 8;

   // Pixel entry at the default framebuffer geometry.
   typedef struct packed {
      logic [FB_ADDR_W-1:0]   addr;
      logic [COLOR_W_DEF-1:0] color;
   } pix_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// Generic synchronous FIFO with full/empty flags.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset (empties the FIFO, clears storage)
//   push_i   write request; ignored while full
//   data_i   write data
//   pop_i    read request; ignored while empty
//   data_o   head entry (valid while !empty_o)
//   full_o   DEPTH entries held
//   empty_o  no entries held
module pixel_fifo #(
   parameter int unsigned WIDTH = 23,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_en;
   logic             pop_en;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_en = push_i && !full_o;
   assign pop_en  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_en) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_en && !pop_en) begin
         count_d = count_q + 1'b1;
      end else if (!push_en && pop_en) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         // Cleared so the head reads as zero straight out of reset.
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
         end
      end
   end

endmodule

// File: rtl/pixel_writer.sv
// Pixel writer: clips incoming (X, Y, colour) points to the visible area,
// converts them to linear framebuffer addresses, queues them in a small FIFO
// and writes them to framebuffer RAM under an arbiter grant.
// Build option: define PIX_DEDUP_EN to drop a point repeating the last
// enqueued (X, Y), as the circle generator emits on its axes.
// Ports:
//   ACLK, ARST                 clock; synchronous active-high reset
//   X_In, Y_In, COLOR          point coordinates and colour
//   PIX_VALID / PIX_READY      input handshake
//   FB_ADDR, FB_DATA, FB_WE    framebuffer write request (head of FIFO)
//   FB_GNT                     grant; a write completes on FB_WE && FB_GNT
//   BUSY                       pixels still queued
//   CLIP_COUNT                 wrapping count of clipped points
module pixel_writer
   import gfx_pkg::*;
#(
   parameter int unsigned H_RES   = H_RES_DEF,
   parameter int unsigned V_RES   = V_RES_DEF,
   parameter int unsigned ADDR_W  = FB_ADDR_W,
   parameter int unsigned COLOR_W = COLOR_W_DEF,
   parameter int unsigned DEPTH   = 4
) (
   input  logic               ACLK,
   input  logic               ARST,
   input  logic [7:0]         X_In,
   input  logic [7:0]         Y_In,
   input  logic [COLOR_W-1:0] COLOR,
   input  logic               PIX_VALID,
   output logic               PIX_READY,
   output logic [ADDR_W-1:0]  FB_ADDR,
   output logic [COLOR_W-1:0] FB_DATA,
   output logic               FB_WE,
   input  logic               FB_GNT,
   output logic               BUSY,
   output logic [15:0]        CLIP_COUNT
);

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [COLOR_W-1:0] color;
   } entry_t;

   entry_t      entry_in;
   entry_t      entry_head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        accept;
   logic        in_range;
   logic        dup;
   logic        push;
   logic [15:0] clip_cnt_q, clip_cnt_d;

   assign PIX_READY = !fifo_full;
   assign accept    = PIX_VALID && PIX_READY;
   assign in_range  = (32'(X_In) < H_RES) && (32'(Y_In) < V_RES);
   assign push      = accept && in_range && !dup;

   assign entry_in.addr  = ADDR_W'(32'(Y_In) * H_RES + 32'(X_In));
   assign entry_in.color = COLOR;

`ifdef PIX_DEDUP_EN
   logic [7:0] last_x_q;
   logic [7:0] last_y_q;
   logic       last_valid_q;

   // Colour is deliberately excluded from the match.
   assign dup = last_valid_q && (X_In == last_x_q) && (Y_In == last_y_q);

   always_ff @(posedge ACLK) begin
      if (ARST) begin
         last_x_q     <= '0;
         last_y_q     <= '0;
         last_valid_q <= 1'b0;
      end else if (push) begin
         last_x_q     <= X_In;
         last_y_q     <= Y_In;
         last_valid_q <= 1'b1;
      end
   end
`else
   assign dup = 1'b0;
`endif

   always_comb begin
      clip_cnt_d = clip_cnt_q;
      if (accept && !in_range) begin
         clip_cnt_d = clip_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARST) begin
         clip_cnt_q <= '0;
      end else begin
         clip_cnt_q <= clip_cnt_d;
      end
   end

   pixel_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (ACLK),
      .rst_i   (ARST),
      .push_i  (push),
      .data_i  (entry_in),
      .pop_i   (FB_GNT),
      .data_o  (entry_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign FB_WE      = !fifo_empty;
   assign BUSY       = !fifo_empty;
   assign FB_ADDR    = entry_head.addr;
   assign FB_DATA    = entry_head.color;
   assign CLIP_COUNT = clip_cnt_q;

endmodule
